// File: rtl/driver_pc.sv
// ---------------------------------------------------------------------------
// singlecycle_pkg + driver_pc
//
// Purpose
//   Constrained-random stimulus driver and reference model for the PC
//   register of the single-cycle core.
//   - Drives a PC DUT with sequential bursts, stalls and word-aligned jumps.
//   - Tracks the PC the DUT should hold.
//   - Counts every cycle on which the DUT's PC disagrees with the model.
//
// Ports
//   i_clk          clock, all logic on posedge
//   i_rst          synchronous active-high reset
//   i_start        pulse: start a run from IDLE or DONE (ignored in RUN)
//   i_abort        pulse: in RUN, return to IDLE on the next edge
//   i_act_pc       PC currently presented by the DUT
//   drv_pc_sel     PC_4 / PC_ALU select driven into the DUT
//   drv_pc_en      PC write enable driven into the DUT
//   drv_alu_res    jump target driven into the DUT, always word aligned
//   o_busy         high while in RUN
//   o_done         sticky high while in DONE
//   o_op_cnt       ops issued in the current run
//   o_exp_pc       model PC
//   o_err_cnt      mismatches since reset, saturating
//   o_first_err_pc i_act_pc captured at the first mismatch, 0 until then
//   o_state        current FSM state (debug)
//
// Control protocol
//   i_start and i_abort are single-cycle pulses sampled on posedge. There is
//   no handshake back: i_start is simply ignored while a run is active, and
//   i_abort is ignored outside RUN. In IDLE, i_start wins over i_abort.
//
// All outputs are driven straight from registers.
// ---------------------------------------------------------------------------
package singlecycle_pkg;
  typedef enum logic {
    PC_4   = 1'b0,
    PC_ALU = 1'b1
  } PCSel_e;
endpackage

module driver_pc
  import singlecycle_pkg::*;
#(
  parameter int          NUM_OPS   = 256,
  parameter logic [31:0] SEED      = 32'h1,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter logic [31:0] ADDR_MASK = 32'h0000_FFFC
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [31:0] i_act_pc,
  output PCSel_e      drv_pc_sel,
  output logic        drv_pc_en,
  output logic [31:0] drv_alu_res,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_op_cnt,
  output logic [31:0] o_exp_pc,
  output logic [15:0] o_err_cnt,
  output logic [31:0] o_first_err_pc,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A zero seed would lock the LFSR at zero forever.
  localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [15:0] OPS_LAST  = 16'(NUM_OPS - 1);
  localparam logic [31:0] TGT_MASK  = ADDR_MASK & ~32'h3;

  state_e      r_state;
  state_e      w_state_nxt;
  logic        w_issue;
  logic        w_clr_cnt;

  logic [31:0] r_lfsr;
  logic [2:0]  r_seq_cnt;
  logic        r_cmp_en;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_op_cnt;
  logic [31:0] r_exp_pc;
  logic [15:0] r_err_cnt;
  logic [31:0] r_first_err_pc;
  PCSel_e      r_pc_sel;
  logic        r_pc_en;
  logic [31:0] r_alu_res;

  logic        w_stall;
  logic        w_jump;
  logic [31:0] w_target;
  logic [31:0] w_lfsr_nxt;

  // Op decision uses the LFSR value before it advances.
  assign w_stall    = (r_lfsr[2:0] == 3'd0);
  assign w_jump     = !w_stall && (r_seq_cnt == 3'd0);
  assign w_target   = r_lfsr & TGT_MASK;
  // Galois, shift right: feedback taps applied when the bit shifted out is 1.
  assign w_lfsr_nxt = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_POLY : 32'h0);

  // ---------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_clr_cnt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
          w_clr_cnt   = 1'b1;
        end
      end
      ST_RUN: begin
        // Abort cancels the op that would otherwise issue this cycle.
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_issue = 1'b1;
          if (r_op_cnt == OPS_LAST) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
          w_clr_cnt   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM state register, stimulus registers, model and checker
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_lfsr         <= SEED_EFF;
      r_seq_cnt      <= 3'd0;
      r_cmp_en       <= 1'b0;
      r_op_cnt       <= 16'd0;
      r_exp_pc       <= RESET_PC;
      r_err_cnt      <= 16'd0;
      r_first_err_pc <= 32'd0;
      r_pc_sel       <= PC_4;
      r_pc_en        <= 1'b0;
      r_alu_res      <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_busy   <= (w_state_nxt == ST_RUN);
      r_done   <= (w_state_nxt == ST_DONE);
      r_cmp_en <= 1'b1;

      if (w_clr_cnt) begin
        r_op_cnt <= 16'd0;
      end

      if (w_issue) begin
        r_op_cnt  <= r_op_cnt + 16'd1;
        r_lfsr    <= w_lfsr_nxt;
        // Target is driven on every op, not only jumps, so a DUT whose
        // mux leaks the ALU input on PC_4 shows up as a mismatch.
        r_alu_res <= w_target;
        r_pc_en   <= !w_stall;
        r_pc_sel  <= w_jump ? PC_ALU : PC_4;
        if (w_jump) begin
          r_seq_cnt <= r_lfsr[10:8];
        end else if (!w_stall) begin
          r_seq_cnt <= r_seq_cnt - 3'd1;
        end
      end else begin
        r_pc_en  <= 1'b0;
        r_pc_sel <= PC_4;
      end

      // The DUT samples the registered drive at this same edge, so the
      // model updates in lockstep with it.
      if (r_pc_en) begin
        if (r_pc_sel == PC_ALU) begin
          r_exp_pc <= r_alu_res;
        end else begin
          r_exp_pc <= r_exp_pc + 32'd4;
        end
      end

      if (r_cmp_en && (i_act_pc != r_exp_pc)) begin
        if (r_err_cnt == 16'd0) begin
          r_first_err_pc <= i_act_pc;
        end
        if (r_err_cnt != 16'hFFFF) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
      end
    end
  end

  assign drv_pc_sel     = r_pc_sel;
  assign drv_pc_en      = r_pc_en;
  assign drv_alu_res    = r_alu_res;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_op_cnt       = r_op_cnt;
  assign o_exp_pc       = r_exp_pc;
  assign o_err_cnt      = r_err_cnt;
  assign o_first_err_pc = r_first_err_pc;
  assign o_state        = r_state;

endmodule

// File: tb/tb_driver_pc.sv
// ---------------------------------------------------------------------------
// tb_driver_pc
//   Directed bench for driver_pc. Three instances share clock/reset/start:
//     u_dut    SEED=1, NUM_OPS=16, driven PC from a local PC register model
//     u_dut_s0 SEED=0 (must behave exactly like SEED=1)
//     u_dut_wr SEED=FFFFFFFF, mask FFFFFFFC, RESET_PC=FFFFFFFC, so its first
//              op jumps to FFFFFFFC and its second op increments past 2^32.
//   The SEED=1 op trace below was worked out by hand from the LFSR.
// ---------------------------------------------------------------------------
module tb_driver_pc;
  import singlecycle_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      = 1'b1;
  logic        start    = 1'b0;
  logic        abort    = 1'b0;
  logic        ignore_alu = 1'b0;
  logic [31:0] act_pc;

  // main instance outputs
  PCSel_e      sel;
  logic        en;
  logic [31:0] alu;
  logic        busy, done;
  logic [15:0] op_cnt, err_cnt;
  logic [31:0] exp_pc, first_err;
  logic [1:0]  state;

  // SEED=0 instance outputs
  PCSel_e      s0_sel;
  logic        s0_en;
  logic [31:0] s0_alu;
  logic        s0_busy, s0_done;
  logic [15:0] s0_op_cnt, s0_err_cnt;
  logic [31:0] s0_exp_pc, s0_first_err;
  logic [1:0]  s0_state;

  // wrap instance outputs
  PCSel_e      wr_sel;
  logic        wr_en;
  logic [31:0] wr_alu;
  logic        wr_busy, wr_done;
  logic [15:0] wr_op_cnt, wr_err_cnt;
  logic [31:0] wr_exp_pc, wr_first_err;
  logic [1:0]  wr_state;

  driver_pc #(.NUM_OPS(16), .SEED(32'h1), .RESET_PC(32'h0), .ADDR_MASK(32'h0000_FFFC)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_act_pc(act_pc),
    .drv_pc_sel(sel), .drv_pc_en(en), .drv_alu_res(alu),
    .o_busy(busy), .o_done(done), .o_op_cnt(op_cnt), .o_exp_pc(exp_pc),
    .o_err_cnt(err_cnt), .o_first_err_pc(first_err), .o_state(state)
  );

  driver_pc #(.NUM_OPS(16), .SEED(32'h0), .RESET_PC(32'h0), .ADDR_MASK(32'h0000_FFFC)) u_dut_s0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_act_pc(act_pc),
    .drv_pc_sel(s0_sel), .drv_pc_en(s0_en), .drv_alu_res(s0_alu),
    .o_busy(s0_busy), .o_done(s0_done), .o_op_cnt(s0_op_cnt), .o_exp_pc(s0_exp_pc),
    .o_err_cnt(s0_err_cnt), .o_first_err_pc(s0_first_err), .o_state(s0_state)
  );

  driver_pc #(.NUM_OPS(16), .SEED(32'hFFFF_FFFF), .RESET_PC(32'hFFFF_FFFC),
              .ADDR_MASK(32'hFFFF_FFFC)) u_dut_wr (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_act_pc(32'h0),
    .drv_pc_sel(wr_sel), .drv_pc_en(wr_en), .drv_alu_res(wr_alu),
    .o_busy(wr_busy), .o_done(wr_done), .o_op_cnt(wr_op_cnt), .o_exp_pc(wr_exp_pc),
    .o_err_cnt(wr_err_cnt), .o_first_err_pc(wr_first_err), .o_state(wr_state)
  );

  // PC register standing in for the real DUT. With ignore_alu set it
  // behaves like a broken PC that always increments.
  always @(posedge clk) begin
    if (rst) begin
      act_pc <= 32'h0;
    end else if (en) begin
      if (sel == PC_ALU && !ignore_alu) act_pc <= alu;
      else                              act_pc <= act_pc + 32'd4;
    end
  end

  // ---------------- scoreboard ----------------
  // Expected op trace for SEED=1: {is_jump, alu_res}. en is 1 on all 16.
  localparam logic [32:0] OP_TBL [16] = '{
    {1'b1, 32'h0000}, {1'b1, 32'h0000}, {1'b1, 32'h0000}, {1'b1, 32'h0000},
    {1'b1, 32'h0000}, {1'b1, 32'h0000}, {1'b1, 32'h0000}, {1'b1, 32'h8000},
    {1'b1, 32'hC000}, {1'b1, 32'h6000}, {1'b1, 32'hB000}, {1'b1, 32'hD800},
    {1'b1, 32'h6C00}, {1'b0, 32'hB600}, {1'b0, 32'hDB00}, {1'b0, 32'h6D80}
  };
  localparam logic [31:0] FINAL_PC = 32'h6C0C;

  logic [32:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Starts a 16-op run and checks the drive trace of u_dut and u_dut_s0
  // against the hand-computed table, then the end-of-run status.
  task automatic check_run(input string tag);
    logic [32:0] e;
    int          busy_cycles;
    for (int i = 0; i < 16; i++) exp_q.push_back(OP_TBL[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_run_state"}, 32'(state), 32'd1);
    busy_cycles = busy ? 1 : 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      e = exp_q.pop_front();
      chk({tag, "_sel"}, 32'(sel), e[32] ? 32'(PC_ALU) : 32'(PC_4));
      chk({tag, "_en"}, 32'(en), 32'd1);
      chk({tag, "_alu"}, alu, e[31:0]);
      chk({tag, "_align"}, 32'(alu[1:0]), 32'd0);
      chk({tag, "_s0_sel"}, 32'(s0_sel), e[32] ? 32'(PC_ALU) : 32'(PC_4));
      chk({tag, "_s0_en"}, 32'(s0_en), 32'd1);
      chk({tag, "_s0_alu"}, s0_alu, e[31:0]);
      chk({tag, "_op_cnt"}, 32'(op_cnt), 32'(k + 1));
      if (busy) busy_cycles++;
    end
    chk({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd16);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_final_op_cnt"}, 32'(op_cnt), 32'd16);
    tick();
    chk({tag, "_done_en"}, 32'(en), 32'd0);
    chk({tag, "_done_sel"}, 32'(sel), 32'(PC_4));
    chk({tag, "_done_sticky"}, 32'(done), 32'd1);
    chk({tag, "_exp_pc"}, exp_pc, FINAL_PC);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // T1: reset then idle
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    chk("t1_en", 32'(en), 32'd0);
    chk("t1_sel", 32'(sel), 32'(PC_4));
    chk("t1_exp_pc", exp_pc, 32'h0);
    chk("t1_err_cnt", 32'(err_cnt), 32'd0);
    chk("t1_first_err", first_err, 32'h0);
    chk("t1_done", 32'(done), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_op_cnt", 32'(op_cnt), 32'd0);
    chk("t1_state", 32'(state), 32'd0);
    chk("t1_wr_exp_pc", wr_exp_pc, 32'hFFFF_FFFC);

    // T2: ideal PC, one run
    check_run("t2");
    chk("t2_err_cnt", 32'(err_cnt), 32'd0);
    chk("t2_act_pc_model", act_pc, FINAL_PC);

    // T3: PC that ignores PC_ALU
    ignore_alu = 1'b1;
    do_reset();
    check_run("t3");
    chk("t3_err_nonzero", 32'(err_cnt != 16'd0), 32'd1);
    chk("t3_first_err_pc", first_err, 32'h4);
    ignore_alu = 1'b0;

    // T4: abort at op_cnt==5, then restart with start+abort together
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t4_op_cnt_5", 32'(op_cnt), 32'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_state_idle", 32'(state), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_en", 32'(en), 32'd0);
    chk("t4_op_cnt_hold", 32'(op_cnt), 32'd5);
    chk("t4_done", 32'(done), 32'd0);
    tick();
    chk("t4_err_cnt", 32'(err_cnt), 32'd0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t4_restart_busy", 32'(busy), 32'd1);
    chk("t4_restart_op_cnt", 32'(op_cnt), 32'd0);
    tick();
    chk("t4_restart_op1", 32'(op_cnt), 32'd1);

    // T5: reset mid-run at op 7, then replay the T2 trace
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("t5_op_cnt_7", 32'(op_cnt), 32'd7);
    rst = 1'b1;
    tick();
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_op_cnt", 32'(op_cnt), 32'd0);
    chk("t5_en", 32'(en), 32'd0);
    chk("t5_sel", 32'(sel), 32'(PC_4));
    chk("t5_alu", alu, 32'h0);
    chk("t5_exp_pc", exp_pc, 32'h0);
    chk("t5_err_cnt", 32'(err_cnt), 32'd0);
    chk("t5_first_err", first_err, 32'h0);
    chk("t5_state", 32'(state), 32'd0);
    rst = 1'b0;
    tick();
    check_run("t5");
    chk("t5_err_after", 32'(err_cnt), 32'd0);

    // T6: exp_pc wraps 0xFFFFFFFC -> 0 on an increment
    do_reset();
    chk("t6_wr_reset_pc", wr_exp_pc, 32'hFFFF_FFFC);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t6_wr_jump_sel", 32'(wr_sel), 32'(PC_ALU));
    chk("t6_wr_jump_alu", wr_alu, 32'hFFFF_FFFC);
    tick();
    chk("t6_wr_inc_sel", 32'(wr_sel), 32'(PC_4));
    chk("t6_wr_inc_en", 32'(wr_en), 32'd1);
    chk("t6_wr_pc_pre", wr_exp_pc, 32'hFFFF_FFFC);
    tick();
    chk("t6_wr_pc_wrap", wr_exp_pc, 32'h0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
